core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the rv32i core: fetch → decode → execute → writeback, with trap entry.
- Owns PC and instruction register, drives the instruction decoder's opcode input, sequences register file, ALU and imem handshakes.
- Sits between instruction memory and the combinational decoder/ALU/register-file datapath; only one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on any trap

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
o_imem_req  out  1  fetch request, held until ack
o_imem_addr  out  32  fetch address (= PC), stable while req high
i_imem_ack  in  1  fetch complete, rdata/err valid this cycle
i_imem_rdata  in  32  fetched instruction word
i_imem_err  in  1  access fault, qualified by ack
o_instr  out  32  instruction register, to decoder i_opcode
i_dec_en_rd  in  1  decoder rd enable
i_dec_rd  in  5  decoder rd
i_dec_en_rs1  in  1  decoder rs1 enable
i_dec_rs1  in  5  decoder rs1
i_dec_en_rs2  in  1  decoder rs2 enable
i_dec_rs2  in  5  decoder rs2
i_dec_en_imm  in  1  decoder immediate enable
i_dec_illegal  in  1  decoder illegal-instruction flag
o_rf_raddr1  out  5  regfile read address 1 (0 if rs1 unused)
o_rf_raddr2  out  5  regfile read address 2 (0 if rs2 unused)
o_alu_src_imm  out  1  ALU operand B select: 1 = immediate
o_alu_start  out  1  one-cycle ALU start pulse
i_alu_done  in  1  ALU result valid
o_rf_we  out  1  regfile write enable, one-cycle pulse
o_rf_waddr  out  5  regfile write address
o_pc  out  32  current PC
o_trap  out  1  one-cycle trap pulse
o_trap_cause  out  2  0 misaligned fetch, 1 fetch access fault, 2 illegal instruction
o_trap_pc  out  32  PC of faulting instruction, valid with o_trap
o_retired  out  32  retired-instruction counter, wraps modulo 2^32

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. Registered state and registered outputs.
- Reset (asynchronous, i_rst_n low): state=IDLE; PC=RESET_PC; o_instr=0; o_retired=0; all other outputs 0.
- IDLE: exactly one cycle after reset release, then FETCH.
- FETCH:
  - If PC[1:0]!=0: no request issued; go to TRAP, cause 0.
  - Otherwise o_imem_req=1 with o_imem_addr=PC, held until the ack cycle.
  - On ack & !err: IR←rdata, req drops the next cycle, go to DECODE.
  - On ack & err: IR unchanged, go to TRAP, cause 1.
  - The PC must not change while req is high.
- DECODE (exactly 1 cycle):
  - Decoder is combinational on o_instr.
  - If i_dec_illegal: go to TRAP, cause 2.
  - Otherwise latch raddr1/raddr2 (0 when not enabled), alu_src_imm, waddr and a we_pending flag (en_rd && rd!=0), then go to EXEC.
  - Latched fields hold through WB.
- EXEC:
  - o_alu_start is high only in the first EXEC cycle.
  - i_alu_done is sampled from the second EXEC cycle onward; done in the start cycle is ignored.
  - Wait indefinitely, then go to WB.
- WB (1 cycle):
  - o_rf_we=we_pending.
  - PC←PC+4, wrapping modulo 2^32 (0xFFFF_FFFC→0).
  - o_retired increments.
  - Go to FETCH.
- TRAP (1 cycle):
  - o_trap=1, cause as above, o_trap_pc=PC.
  - PC←TRAP_VECTOR; o_retired unchanged; no regfile write.
  - Go to FETCH.
- Minimum latency for a legal instruction with a 1-cycle ack and 1-cycle ALU: FETCH 1 + DECODE 1 + EXEC 2 + WB 1 = 5 cycles.
- Reset mid-operation (e.g. req high, or inside EXEC): all state is discarded immediately. No rf_we or trap pulse may escape, and req drops asynchronously.
- ack outside FETCH is ignored.
- A trap in TRAP_VECTOR itself is legal and loops. This is not detected.

Decomposition:
- Shared package core_pkg:
  - state enum (IDLE..TRAP)
  - trap cause constants (CAUSE_MISALIGNED=0, CAUSE_FETCH_FAULT=1, CAUSE_ILLEGAL=2)
  - opcode constants shared with the decoder (OP, OP_IMM, ...)
- One natural sub-module: core_pc_reg. It holds the PC, with a load-vector / increment-by-4 / hold select and the parameterised reset value.

Test Plan:
- Reset release, imem acks after 3 wait cycles with ADDI x1,x0,5 (0x00500093), ALU done 1 cycle after start → addr 0x0 held 3 cycles; raddr1=0, alu_src_imm=1; rf_we pulse with waddr=1; PC=0x4; o_retired=1.
- ADD x3,x1,x2 (0x002081B3) → raddr1=1, raddr2=2, alu_src_imm=0, waddr=3, single rf_we pulse.
- Word 0x00000000 (illegal) at PC 0x8 → o_trap=1, cause=2, trap_pc=0x8; next fetch addr=0x100; retired unchanged; no rf_we.
- ack with err at PC 0x4 → trap cause 1, trap_pc=0x4; IR unchanged; next fetch 0x100.
- ADDI x0,x0,0 (0x00000013) → no rf_we, PC+4, retired increments. Separately, RESET_PC=0xFFFF_FFFC with a legal instruction → PC wraps to 0x0.
- Assert i_rst_n low mid-EXEC and mid-FETCH → outputs zero immediately, no rf_we/trap pulse; after release, IDLE then fetch from RESET_PC. Also check RESET_PC=0x2 → trap cause 0 with no imem_req ever asserted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the rv32i multi-cycle core: sequencer states,
// trap causes, PC update selects and base opcodes shared with the decoder.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_VEC
  } pc_sel_t;

  localparam logic [1:0] CAUSE_MISALIGNED  = 2'd0;
  localparam logic [1:0] CAUSE_FETCH_FAULT = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd2;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP          = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/core_pc_reg.sv
// Program counter: hold, advance by one word (wrapping) or jump to the trap vector.
module core_pc_reg
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_t     sel,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + 32'd4;
        PC_VEC:  pc <= TRAP_VECTOR;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with trap entry; one
// instruction in flight, all outputs registered.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  output logic [31:0] o_instr,
  input  logic        i_dec_en_rd,
  input  logic [4:0]  i_dec_rd,
  input  logic        i_dec_en_rs1,
  input  logic [4:0]  i_dec_rs1,
  input  logic        i_dec_en_rs2,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_en_imm,
  input  logic        i_dec_illegal,
  output logic [4:0]  o_rf_raddr1,
  output logic [4:0]  o_rf_raddr2,
  output logic        o_alu_src_imm,
  output logic        o_alu_start,
  input  logic        i_alu_done,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_pc,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [31:0] o_trap_pc,
  output logic [31:0] o_retired
);

  localparam logic VEC_ALIGNED = (TRAP_VECTOR[1:0] == 2'b00);

  state_t      state;
  pc_sel_t     pc_sel;
  logic [31:0] pc;
  logic [31:0] instr_reg;
  logic        imem_req_reg;
  logic [4:0]  raddr1_reg;
  logic [4:0]  raddr2_reg;
  logic        alu_src_imm_reg;
  logic        alu_start_reg;
  logic        we_pending_reg;
  logic        rf_we_reg;
  logic [4:0]  waddr_reg;
  logic        trap_reg;
  logic [1:0]  trap_cause_reg;
  logic [31:0] trap_pc_reg;
  logic [31:0] retired_reg;

  // The PC only moves at the end of WB or TRAP, so it is frozen for the whole fetch.
  always_comb begin
    pc_sel = PC_HOLD;
    if (state == WB)
      pc_sel = PC_INC;
    else if (state == TRAP)
      pc_sel = PC_VEC;
  end

  core_pc_reg #(
    .RESET_PC    (RESET_PC),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_reg (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .sel   (pc_sel),
    .pc    (pc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      instr_reg       <= '0;
      imem_req_reg    <= 1'b0;
      raddr1_reg      <= '0;
      raddr2_reg      <= '0;
      alu_src_imm_reg <= 1'b0;
      alu_start_reg   <= 1'b0;
      we_pending_reg  <= 1'b0;
      rf_we_reg       <= 1'b0;
      waddr_reg       <= '0;
      trap_reg        <= 1'b0;
      trap_cause_reg  <= '0;
      trap_pc_reg     <= '0;
      retired_reg     <= '0;
    end else begin
      alu_start_reg <= 1'b0;
      rf_we_reg     <= 1'b0;
      trap_reg      <= 1'b0;
      case (state)
        IDLE: begin
          state        <= FETCH;
          imem_req_reg <= (pc[1:0] == 2'b00);
        end
        FETCH: begin
          if (pc[1:0] != 2'b00) begin
            state          <= TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= CAUSE_MISALIGNED;
            trap_pc_reg    <= pc;
          end else if (i_imem_ack) begin
            imem_req_reg <= 1'b0;
            if (i_imem_err) begin
              state          <= TRAP;
              trap_reg       <= 1'b1;
              trap_cause_reg <= CAUSE_FETCH_FAULT;
              trap_pc_reg    <= pc;
            end else begin
              instr_reg <= i_imem_rdata;
              state     <= DECODE;
            end
          end
        end
        DECODE: begin
          if (i_dec_illegal) begin
            state          <= TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= CAUSE_ILLEGAL;
            trap_pc_reg    <= pc;
          end else begin
            raddr1_reg      <= i_dec_en_rs1 ? i_dec_rs1 : 5'd0;
            raddr2_reg      <= i_dec_en_rs2 ? i_dec_rs2 : 5'd0;
            alu_src_imm_reg <= i_dec_en_imm;
            waddr_reg       <= i_dec_rd;
            we_pending_reg  <= i_dec_en_rd && (i_dec_rd != 5'd0);
            alu_start_reg   <= 1'b1;
            state           <= EXEC;
          end
        end
        EXEC: begin
          // alu_start_reg marks the first EXEC cycle; a done seen there is stale.
          if (!alu_start_reg && i_alu_done) begin
            rf_we_reg <= we_pending_reg;
            state     <= WB;
          end
        end
        WB: begin
          retired_reg  <= retired_reg + 32'd1;
          imem_req_reg <= (pc[1:0] == 2'b00);
          state        <= FETCH;
        end
        TRAP: begin
          imem_req_reg <= VEC_ALIGNED;
          state        <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_imem_req    = imem_req_reg;
  assign o_imem_addr   = pc;
  assign o_instr       = instr_reg;
  assign o_rf_raddr1   = raddr1_reg;
  assign o_rf_raddr2   = raddr2_reg;
  assign o_alu_src_imm = alu_src_imm_reg;
  assign o_alu_start   = alu_start_reg;
  assign o_rf_we       = rf_we_reg;
  assign o_rf_waddr    = waddr_reg;
  assign o_pc          = pc;
  assign o_trap        = trap_reg;
  assign o_trap_cause  = trap_cause_reg;
  assign o_trap_pc     = trap_pc_reg;
  assign o_retired     = retired_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against an instruction-level model; two
// extra instances cover PC wrap and a misaligned reset PC.
module tb_core_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en_rd;
    logic [4:0] rd;
    logic       en_rs1;
    logic [4:0] rs1;
    logic       en_rs2;
    logic [4:0] rs2;
    logic       en_imm;
    logic       illegal;
  } dec_t;

  // Reference rv32i base-opcode decoder standing in for the real one.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.rd  = w[11:7];
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    case (w[6:0])
      7'b0110011: begin d.en_rd = 1; d.en_rs1 = 1; d.en_rs2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin d.en_rd = 1; d.en_rs1 = 1; d.en_imm = 1; end
      7'b0100011, 7'b1100011: begin d.en_rs1 = 1; d.en_rs2 = 1; d.en_imm = 1; end
      7'b0110111, 7'b0010111, 7'b1101111: begin d.en_rd = 1; d.en_imm = 1; end
      default: d.illegal = 1;
    endcase
    return d;
  endfunction

  // ---------------- main instance ----------------
  logic        imem_req, imem_ack, imem_err, alu_start, alu_done, rf_we, trap, alu_src_imm;
  logic [31:0] imem_addr, imem_rdata, instr, pc, trap_pc, retired;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [1:0]  trap_cause;
  dec_t        dec0;

  always_comb dec0 = decode(instr);

  core_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata), .i_imem_err(imem_err), .o_instr(instr),
    .i_dec_en_rd(dec0.en_rd), .i_dec_rd(dec0.rd), .i_dec_en_rs1(dec0.en_rs1),
    .i_dec_rs1(dec0.rs1), .i_dec_en_rs2(dec0.en_rs2), .i_dec_rs2(dec0.rs2),
    .i_dec_en_imm(dec0.en_imm), .i_dec_illegal(dec0.illegal),
    .o_rf_raddr1(raddr1), .o_rf_raddr2(raddr2), .o_alu_src_imm(alu_src_imm),
    .o_alu_start(alu_start), .i_alu_done(alu_done), .o_rf_we(rf_we), .o_rf_waddr(waddr),
    .o_pc(pc), .o_trap(trap), .o_trap_cause(trap_cause), .o_trap_pc(trap_pc),
    .o_retired(retired)
  );

  // ---------------- parameter-variant instances ----------------
  logic        req1, ack1, req2, ack2, trap1, trap2, start1, start2, we1, we2, simm1, simm2;
  logic [31:0] addr1, addr2, ins1, ins2, pc1, pc2, tpc1, tpc2, ret1, ret2;
  logic [4:0]  ra1a, ra1b, ra2a, ra2b, wa1, wa2;
  logic [1:0]  cause1, cause2;
  logic [31:0] const_word = 32'h0050_0093;

  core_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_ack(ack1),
    .i_imem_rdata(const_word), .i_imem_err(1'b0), .o_instr(ins1),
    .i_dec_en_rd(1'b1), .i_dec_rd(5'd1), .i_dec_en_rs1(1'b1), .i_dec_rs1(5'd0),
    .i_dec_en_rs2(1'b0), .i_dec_rs2(5'd5), .i_dec_en_imm(1'b1), .i_dec_illegal(1'b0),
    .o_rf_raddr1(ra1a), .o_rf_raddr2(ra1b), .o_alu_src_imm(simm1),
    .o_alu_start(start1), .i_alu_done(1'b1), .o_rf_we(we1), .o_rf_waddr(wa1),
    .o_pc(pc1), .o_trap(trap1), .o_trap_cause(cause1), .o_trap_pc(tpc1),
    .o_retired(ret1)
  );

  core_sequencer #(.RESET_PC(32'h0000_0002)) dut_mis (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_ack(ack2),
    .i_imem_rdata(const_word), .i_imem_err(1'b0), .o_instr(ins2),
    .i_dec_en_rd(1'b1), .i_dec_rd(5'd1), .i_dec_en_rs1(1'b1), .i_dec_rs1(5'd0),
    .i_dec_en_rs2(1'b0), .i_dec_rs2(5'd5), .i_dec_en_imm(1'b1), .i_dec_illegal(1'b0),
    .o_rf_raddr1(ra2a), .o_rf_raddr2(ra2b), .o_alu_src_imm(simm2),
    .o_alu_start(start2), .i_alu_done(1'b1), .o_rf_we(we2), .o_rf_waddr(wa2),
    .o_pc(pc2), .o_trap(trap2), .o_trap_cause(cause2), .o_trap_pc(tpc2),
    .o_retired(ret2)
  );

  // Simple one-wait-state memory responders for the variant instances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack1 <= 1'b0;
      ack2 <= 1'b0;
    end else begin
      ack1 <= req1 && !ack1;
      ack2 <= req2 && !ack2;
    end
  end

  bit          got1, got2, req2_early;
  logic [31:0] pc1_at_retire, tpc2_at;
  logic [1:0]  cause2_at;

  always @(negedge clk) begin
    if (rst_n && !got1 && ret1 == 32'd1) begin
      got1 = 1;
      pc1_at_retire = pc1;
    end
    if (rst_n && !got2 && req2) req2_early = 1;
    if (rst_n && !got2 && trap2) begin
      got2 = 1;
      cause2_at = cause2;
      tpc2_at = tpc2;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse counters on the main instance, compared with the model at the end.
  int we_seen = 0;
  int trap_seen = 0;
  always @(negedge clk) begin
    if (rf_we) we_seen++;
    if (trap) trap_seen++;
  end

  // Instruction-level model state.
  logic [31:0] exp_pc, exp_ret, exp_ir;
  int          exp_we_cnt = 0;
  int          exp_trap_cnt = 0;

  task automatic expect_trap(input logic [1:0] cause);
    check_eq("trap_pulse", 32'(trap), 32'd1);
    check_eq("trap_cause", 32'(trap_cause), 32'(cause));
    check_eq("trap_pc", trap_pc, exp_pc);
    check_eq("trap_no_we", 32'(rf_we), 32'd0);
    check_eq("trap_ir", instr, exp_ir);
    exp_trap_cnt++;
    @(negedge clk);
    exp_pc = 32'h0000_0100;
    check_eq("trap_one_cycle", 32'(trap), 32'd0);
    check_eq("trap_vec_pc", pc, exp_pc);
    check_eq("trap_retired", retired, exp_ret);
  endtask

  task automatic run_instr(input logic [31:0] word, input bit err,
                           input int ack_delay, input int alu_delay);
    dec_t d;
    bit   exp_we;
    int   n;
    $display("instr pc=%h word=%h err=%0d ack_wait=%0d alu_wait=%0d",
             exp_pc, word, err, ack_delay, alu_delay);
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      check_eq("req_hold", 32'(imem_req), 32'd1);
      check_eq("addr_hold", imem_addr, exp_pc);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    imem_err = err;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_err = 1'b0;
    imem_rdata = $urandom;
    check_eq("req_drop", 32'(imem_req), 32'd0);
    if (err) begin
      expect_trap(2'd1);
      return;
    end
    exp_ir = word;
    check_eq("ir_load", instr, exp_ir);
    d = decode(word);
    @(negedge clk);
    if (d.illegal) begin
      expect_trap(2'd2);
      return;
    end
    check_eq("alu_start", 32'(alu_start), 32'd1);
    check_eq("raddr1", 32'(raddr1), d.en_rs1 ? 32'(d.rs1) : 32'd0);
    check_eq("raddr2", 32'(raddr2), d.en_rs2 ? 32'(d.rs2) : 32'd0);
    check_eq("src_imm", 32'(alu_src_imm), 32'(d.en_imm));
    alu_done = 1'($urandom_range(0, 1));  // must be ignored in the start cycle
    @(negedge clk);
    check_eq("alu_start_once", 32'(alu_start), 32'd0);
    alu_done = 1'b0;
    for (int i = 0; i < alu_delay; i++) begin
      imem_ack = 1'($urandom_range(0, 1));  // stray acks outside FETCH
      imem_err = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    imem_err = 1'b0;
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    exp_we = d.en_rd && (d.rd != 5'd0);
    check_eq("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) check_eq("rf_waddr", 32'(waddr), 32'(d.rd));
    check_eq("ir_stable", instr, exp_ir);
    if (exp_we) exp_we_cnt++;
    @(negedge clk);
    exp_pc = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    check_eq("pc_next", pc, exp_pc);
    check_eq("retired", retired, exp_ret);
    check_eq("we_one_cycle", 32'(rf_we), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
    check_eq({tag, "_we"}, 32'(rf_we), 32'd0);
    check_eq({tag, "_trap"}, 32'(trap), 32'd0);
    check_eq({tag, "_start"}, 32'(alu_start), 32'd0);
    check_eq({tag, "_pc"}, pc, 32'd0);
    check_eq({tag, "_ir"}, instr, 32'd0);
    check_eq({tag, "_retired"}, retired, 32'd0);
  endtask

  task automatic reset_model();
    exp_pc = 32'd0;
    exp_ret = 32'd0;
    exp_ir = 32'd0;
  endtask

  task automatic release_and_check_idle();
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("idle_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_eq("fetch_after_idle", 32'(imem_req), 32'd1);
    check_eq("fetch_reset_pc", imem_addr, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [6:0] ops [0:9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};

  initial begin
    logic [31:0] w;
    int n;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_err = 1'b0;
    imem_rdata = '0;
    alu_done = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Variant instances: PC wrap and misaligned reset PC.
    n = 0;
    while (!(got1 && got2) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("wrap_retired_seen", 32'(got1), 32'd1);
    check_eq("wrap_pc", pc1_at_retire, 32'd0);
    check_eq("mis_trap_seen", 32'(got2), 32'd1);
    check_eq("mis_cause", 32'(cause2_at), 32'd0);
    check_eq("mis_trap_pc", tpc2_at, 32'h0000_0002);
    check_eq("mis_no_req", 32'(req2_early), 32'd0);

    // Directed sequence.
    run_instr(32'h0050_0093, 1'b0, 3, 0);  // ADDI x1,x0,5
    run_instr(32'h0020_81B3, 1'b0, 0, 2);  // ADD x3,x1,x2
    run_instr(32'h0000_0000, 1'b0, 1, 0);  // illegal at 0x8
    run_instr(32'h0000_0013, 1'b0, 0, 0);  // NOP at 0x100
    run_instr(32'h0050_0093, 1'b1, 2, 0);  // fetch fault at 0x104

    // Reset in the middle of EXEC.
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_exec");
    reset_model();
    release_and_check_idle();

    // Reset while the fetch request is outstanding.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_fetch");
    release_and_check_idle();

    run_instr(32'h0050_0093, 1'b0, 1, 0);  // ADDI at 0x0
    run_instr(32'h0020_81B3, 1'b1, 0, 0);  // fault at 0x4

    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) w = 32'd0;
      run_instr(w, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    check_eq("we_pulse_total", 32'(we_seen), 32'(exp_we_cnt));
    check_eq("trap_pulse_total", 32'(trap_seen), 32'(exp_trap_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
